// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and constants for the USB RX packet path
// Contents: controller state encoding, SYNC/size defaults, PID codes and a
// PID check helper.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PID      = 2'd1,
    ST_DATA     = 2'd2,
    ST_EOP_WAIT = 2'd3
  } rx_state_e;

  // Shift register value right after the last SYNC bit (0000000 then 1, LSB-first).
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h80;
  localparam int         MAX_BYTES_DEFAULT = 66;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  // Upper nibble of a PID byte carries the complement of the lower nibble.
  function automatic logic pid_ok(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

endpackage

// File: rtl/rx_packet_controller_if.sv
// rtl/rx_packet_controller_if.sv - bit stream in, FIFO/status out bundle
// master: controller side (samples bit_valid/decoded/eop, drives the rest)
// slave : decoder/FIFO/protocol side (mirror of master)
interface rx_packet_controller_if;
  logic       bit_valid;
  logic       decoded;
  logic       eop;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic [3:0] rx_pid;
  logic       pkt_start;
  logic       pkt_done;
  logic       rx_error;
  logic       receiving;
  logic [6:0] byte_count;

  modport master (
    input  bit_valid, decoded, eop,
    output rx_data, rx_data_valid, rx_pid, pkt_start, pkt_done,
           rx_error, receiving, byte_count
  );

  modport slave (
    output bit_valid, decoded, eop,
    input  rx_data, rx_data_valid, rx_pid, pkt_start, pkt_done,
           rx_error, receiving, byte_count
  );
endinterface

// File: rtl/rx_bit_unstuff.sv
// rtl/rx_bit_unstuff.sv - consecutive-ones tracker and bit-unstuff decision
// Ports: clk, rst (async, active high); bit_valid, decoded, en (unstuffing
// active); load_one (SYNC seen, its last bit was a 1); clear (back to idle);
// bit_accept / bit_drop / stuff_err are combinational per-bit decisions.
module rx_bit_unstuff (
  input  logic clk,
  input  logic rst,
  input  logic bit_valid,
  input  logic decoded,
  input  logic en,
  input  logic load_one,
  input  logic clear,
  output logic bit_accept,
  output logic bit_drop,
  output logic stuff_err
);

  logic [2:0] ones_cnt;
  logic       six_ones;

  assign six_ones   = (ones_cnt == 3'd6);
  assign bit_accept = en && bit_valid && !six_ones;
  assign bit_drop   = en && bit_valid && six_ones && !decoded;
  assign stuff_err  = en && bit_valid && six_ones && decoded;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_cnt <= 3'd0;
    end else if (load_one) begin
      ones_cnt <= 3'd1;
    end else if (clear || bit_drop) begin
      ones_cnt <= 3'd0;
    end else if (bit_accept) begin
      ones_cnt <= decoded ? ones_cnt + 3'd1 : 3'd0;
    end
  end

endmodule

// File: rtl/rx_packet_controller.sv
// rtl/rx_packet_controller.sv - USB RX sequencer: SYNC, unstuff, bytes, PID, EOP
// Ports: clk, rst (async, active high); bus (rx_packet_controller_if.master):
// bit_valid/decoded/eop in; rx_data/rx_data_valid to the FIFO; rx_pid,
// pkt_start, pkt_done, rx_error, receiving, byte_count to the protocol layer.
module rx_packet_controller
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         MAX_BYTES = MAX_BYTES_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  rx_packet_controller_if.master   bus
);

  rx_state_e  state;
  logic [7:0] sreg;
  logic [2:0] bit_cnt;
  logic [7:0] rx_data_q;
  logic       rx_data_valid_q;
  logic [3:0] rx_pid_q;
  logic       pkt_start_q;
  logic       pkt_done_q;
  logic       rx_error_q;
  logic       receiving_q;
  logic [6:0] byte_count_q;

  logic [7:0] new_byte;
  logic       unstuff_en;
  logic       sync_hit;
  logic       eop_exit;
  logic       bit_accept;
  logic       bit_drop;
  logic       stuff_err;

  assign new_byte   = {bus.decoded, sreg[7:1]};
  // EOP takes priority over the data bit, so unstuffing is off in that cycle.
  assign unstuff_en = ((state == ST_PID) || (state == ST_DATA)) && !bus.eop;
  assign sync_hit   = (state == ST_IDLE) && bus.bit_valid && (new_byte == SYNC_BYTE);
  assign eop_exit   = (state == ST_EOP_WAIT) && bus.bit_valid && !bus.eop;

  rx_bit_unstuff u_unstuff (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bus.bit_valid),
    .decoded    (bus.decoded),
    .en         (unstuff_en),
    .load_one   (sync_hit),
    .clear      (eop_exit),
    .bit_accept (bit_accept),
    .bit_drop   (bit_drop),
    .stuff_err  (stuff_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      sreg            <= 8'hFF;
      bit_cnt         <= 3'd0;
      rx_data_q       <= 8'h00;
      rx_data_valid_q <= 1'b0;
      rx_pid_q        <= 4'h0;
      pkt_start_q     <= 1'b0;
      pkt_done_q      <= 1'b0;
      rx_error_q      <= 1'b0;
      receiving_q     <= 1'b0;
      byte_count_q    <= 7'd0;
    end else begin
      rx_data_valid_q <= 1'b0;
      pkt_start_q     <= 1'b0;
      pkt_done_q      <= 1'b0;
      rx_error_q      <= 1'b0;
      if (bus.bit_valid) begin
        case (state)
          ST_IDLE: begin
            sreg <= new_byte;
            if (sync_hit) begin
              state       <= ST_PID;
              receiving_q <= 1'b1;
              bit_cnt     <= 3'd0;
            end
          end
          ST_PID: begin
            if (bus.eop || stuff_err) begin
              rx_error_q <= 1'b1;
              state      <= ST_EOP_WAIT;
            end else if (bit_drop) begin
              // Stuffed bit: nothing assembled, bit_cnt holds.
              sreg <= sreg;
            end else if (bit_accept) begin
              sreg    <= new_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (pid_ok(new_byte)) begin
                  rx_pid_q     <= new_byte[3:0];
                  pkt_start_q  <= 1'b1;
                  byte_count_q <= 7'd0;
                  state        <= ST_DATA;
                end else begin
                  rx_error_q <= 1'b1;
                  state      <= ST_EOP_WAIT;
                end
              end
            end
          end
          ST_DATA: begin
            if (bus.eop) begin
              // Only a byte-aligned EOP ends the packet cleanly.
              if (bit_cnt == 3'd0) pkt_done_q <= 1'b1;
              else                 rx_error_q <= 1'b1;
              state <= ST_EOP_WAIT;
            end else if (stuff_err) begin
              rx_error_q <= 1'b1;
              state      <= ST_EOP_WAIT;
            end else if (bit_drop) begin
              sreg <= sreg;
            end else if (bit_accept) begin
              sreg    <= new_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (byte_count_q >= 7'(MAX_BYTES)) begin
                  rx_error_q <= 1'b1;
                  state      <= ST_EOP_WAIT;
                end else begin
                  rx_data_q       <= new_byte;
                  rx_data_valid_q <= 1'b1;
                  byte_count_q    <= byte_count_q + 7'd1;
                end
              end
            end
          end
          ST_EOP_WAIT: begin
            if (!bus.eop) begin
              state       <= ST_IDLE;
              receiving_q <= 1'b0;
              sreg        <= 8'hFF;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_data_valid = rx_data_valid_q;
  assign bus.rx_pid        = rx_pid_q;
  assign bus.pkt_start     = pkt_start_q;
  assign bus.pkt_done      = pkt_done_q;
  assign bus.rx_error      = rx_error_q;
  assign bus.receiving     = receiving_q;
  assign bus.byte_count    = byte_count_q;

endmodule

// File: tb/tb_rx_packet_controller.sv
// tb/tb_rx_packet_controller.sv - scoreboard bench for rx_packet_controller
module tb_rx_packet_controller;
  import usb_rx_pkg::*;

  localparam logic [3:0] K_DATA  = 4'h1;
  localparam logic [3:0] K_START = 4'h2;
  localparam logic [3:0] K_DONE  = 4'h3;
  localparam logic [3:0] K_ERR   = 4'h4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_packet_controller_if bus ();

  rx_packet_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  int          ones;
  logic        bv_seen;
  logic [15:0] obs_ev;
  int          npulse;
  logic [7:0]  pl[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void expect_ev(input logic [3:0] kind, input logic [11:0] val);
    exp_q.push_back({kind, val});
  endfunction

  // Monitor: every status/data pulse is popped against the scoreboard.
  always @(posedge clk) bv_seen <= bus.bit_valid;

  always @(negedge clk) begin
    if (!rst) begin
      npulse = int'(bus.rx_data_valid) + int'(bus.pkt_start) +
               int'(bus.pkt_done) + int'(bus.rx_error);
      if (npulse > 0) begin
        if (bus.rx_data_valid)  obs_ev = {K_DATA, 4'h0, bus.rx_data};
        else if (bus.pkt_start) obs_ev = {K_START, 8'h00, bus.rx_pid};
        else if (bus.pkt_done)  obs_ev = {K_DONE, 5'h00, bus.byte_count};
        else                    obs_ev = {K_ERR, 12'h000};
        check("single_pulse", npulse, 1);
        check("pulse_latency", bv_seen, 1'b1);
        if (exp_q.size() == 0) check("unexpected_event", obs_ev, 16'hFFFF);
        else                   check("event", obs_ev, exp_q.pop_front());
      end
    end
  end

  task automatic send_bit(input logic d, input logic e);
    @(negedge clk);
    bus.bit_valid = 1'b1;
    bus.decoded   = d;
    bus.eop       = e;
    @(negedge clk);
    bus.bit_valid = 1'b0;
    bus.decoded   = 1'b1;
    bus.eop       = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_raw(input logic d);
    send_bit(d, 1'b0);
    ones = d ? ones + 1 : 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      send_raw(b[i]);
      if (ones == 6) send_raw(1'b0);
    end
  endtask

  task automatic send_sync();
    repeat (3) send_bit(1'b1, 1'b0);
    repeat (7) send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ones = 1;
  endtask

  task automatic send_eop();
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
  endtask

  task automatic send_packet(input logic [3:0] pid, input logic [7:0] bytes[$]);
    send_sync();
    expect_ev(K_START, 12'(pid));
    send_byte({~pid, pid});
    foreach (bytes[i]) begin
      expect_ev(K_DATA, 12'(bytes[i]));
      send_byte(bytes[i]);
    end
    expect_ev(K_DONE, 12'(bytes.size()));
    send_eop();
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {bus.rx_data, bus.rx_data_valid, bus.rx_pid, bus.pkt_start,
                bus.pkt_done, bus.rx_error, bus.receiving, bus.byte_count}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.bit_valid = 1'b0;
    bus.decoded   = 1'b1;
    bus.eop       = 1'b0;
    ones = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;

    // ACK, zero-length, receiving drops on the first J after SE0s.
    send_sync();
    check("receiving_after_sync", bus.receiving, 1'b1);
    expect_ev(K_START, 12'(PID_ACK));
    send_byte({~PID_ACK, PID_ACK});
    check("ack_pid", bus.rx_pid, 4'h2);
    expect_ev(K_DONE, 12'd0);
    send_bit(1'b0, 1'b1);
    check("receiving_se0_1", bus.receiving, 1'b1);
    send_bit(1'b0, 1'b1);
    check("receiving_se0_2", bus.receiving, 1'b1);
    send_bit(1'b1, 1'b0);
    check("receiving_after_j", bus.receiving, 1'b0);
    check("ack_byte_count", bus.byte_count, 7'd0);

    // DATA0 with two payload bytes.
    pl.delete(); pl.push_back(8'hA5); pl.push_back(8'h3C);
    send_packet(PID_DATA0, pl);
    check("data0_byte_count", bus.byte_count, 7'd2);

    // Payload forcing a stuffed zero.
    pl.delete(); pl.push_back(8'hFF); pl.push_back(8'h01);
    send_packet(PID_DATA0, pl);
    check("stuff_byte_count", bus.byte_count, 7'd2);

    // Seven consecutive ones: stuff error, no data, no done.
    send_sync();
    expect_ev(K_START, 12'(PID_DATA1));
    send_byte({~PID_DATA1, PID_DATA1});
    expect_ev(K_ERR, 12'h0);
    repeat (7) send_raw(1'b1);
    check("stuff_err_receiving", bus.receiving, 1'b1);
    send_eop();
    check("stuff_err_idle", bus.receiving, 1'b0);

    // Bad PID: error, rx_pid holds the previous PID.
    send_sync();
    expect_ev(K_ERR, 12'h0);
    send_byte(8'h22);
    send_eop();
    check("bad_pid_holds", bus.rx_pid, PID_DATA1);

    // EOP three bits into a data byte.
    send_sync();
    expect_ev(K_START, 12'(PID_DATA1));
    send_byte({~PID_DATA1, PID_DATA1});
    expect_ev(K_DATA, 12'h05A);
    send_byte(8'h5A);
    send_raw(1'b1); send_raw(1'b0); send_raw(1'b1);
    expect_ev(K_ERR, 12'h0);
    send_eop();

    // Overflow: 66 bytes accepted, the 67th raises an error.
    send_sync();
    expect_ev(K_START, 12'(PID_DATA0));
    send_byte({~PID_DATA0, PID_DATA0});
    for (int i = 0; i < 67; i++) begin
      if (i < 66) expect_ev(K_DATA, 12'(i));
      else        expect_ev(K_ERR, 12'h0);
      send_byte(8'(i));
    end
    send_eop();
    check("overflow_byte_count", bus.byte_count, 7'd66);

    // Reset after three payload bytes, then a clean packet.
    send_sync();
    expect_ev(K_START, 12'(PID_DATA0));
    send_byte({~PID_DATA0, PID_DATA0});
    for (int i = 0; i < 3; i++) begin
      expect_ev(K_DATA, 12'(8'h11 * (i + 1)));
      send_byte(8'(8'h11 * (i + 1)));
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_packet_reset");
    check("reset_queue_drained", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    pl.delete(); pl.push_back(8'h77);
    send_packet(PID_DATA1, pl);
    check("post_reset_pid", bus.rx_pid, PID_DATA1);
    check("post_reset_byte_count", bus.byte_count, 7'd1);

    repeat (8) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_packet_controller.md
Name: rx_packet_controller

Overview:
Sequences the USB RX datapath. It consumes the NRZI-decoded bit stream and the EOP flag from the RX decoder, sampled on a one-cycle bit strobe from the bit timer. It detects SYNC, removes stuffed bits, assembles bytes LSB-first, validates the PID and frames the packet on EOP. It drives byte-write strobes to the RX FIFO and status pulses to the protocol layer.

Parameters:
SYNC_BYTE, 8'h80, value of the shift register after the last SYNC bit (decoded bits 0,0,0,0,0,0,0,1 shifted into bit 7).
MAX_BYTES, 66, maximum bytes after PID, including CRC; exceeding this is an overflow error.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
bit_valid  input  1  one-cycle strobe; decoded and eop are sampled only when it is high
decoded  input  1  decoded bit (1 = no transition)
eop  input  1  SE0 seen on the bus
rx_data  output  8  assembled byte; valid while rx_data_valid is high
rx_data_valid  output  1  one-cycle pulse per payload byte (FIFO write enable)
rx_pid  output  4  PID[3:0] of the current packet; held until the next PID
pkt_start  output  1  one-cycle pulse when a valid PID is accepted
pkt_done  output  1  one-cycle pulse on a clean, byte-aligned EOP
rx_error  output  1  one-cycle pulse on any error
receiving  output  1  high from SYNC match until return to IDLE
byte_count  output  7  number of payload bytes in the current packet

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE and all outputs are 0. Shift register is loaded with 8'hFF, bit_cnt=0, ones_cnt=0.
- All outputs are registered. Every state action happens only in cycles with bit_valid=1; other cycles hold state.
- When eop=1 and bit_valid=1 in the same cycle, EOP handling takes priority and decoded is ignored.
- IDLE: shift decoded into bit 7 (shift right). If the new value equals SYNC_BYTE, go to PID with receiving=1, ones_cnt=1 and bit_cnt=0. eop is ignored in IDLE.
- Unstuff rule, applied in PID and DATA:
  - If ones_cnt==6 and decoded=0: drop the bit, set ones_cnt=0, do not advance bit_cnt.
  - If ones_cnt==6 and decoded=1: stuff error.
  - Otherwise: accept the bit. ones_cnt = decoded ? ones_cnt+1 : 0; bit_cnt = bit_cnt+1 (wraps at 8).
- PID: accept 8 bits.
  - On the 8th bit, if byte[7:4] == ~byte[3:0]: rx_pid<=byte[3:0], pulse pkt_start, byte_count=0, go to DATA.
  - If the check fails, PID error.
  - eop sampled in PID is an error.
- DATA: on each completed byte, rx_data<=byte, pulse rx_data_valid, byte_count++.
  - If byte_count would exceed MAX_BYTES, overflow error; the byte is not written.
  - If eop is sampled with bit_cnt==0, pulse pkt_done and go to EOP_WAIT.
  - If eop is sampled with bit_cnt!=0, alignment error.
- EOP_WAIT: hold until a bit_valid cycle with eop=0, then go to IDLE. On that transition: receiving=0, shift register=8'hFF, ones_cnt=0.
- Any error: pulse rx_error for one cycle, go to EOP_WAIT. No further rx_data_valid, pkt_start or pkt_done for that packet.
- Latency: rx_data_valid asserts the cycle after the bit_valid that carries a byte's 8th accepted bit. pkt_done asserts the cycle after the EOP sample.
- Zero-length packets (EOP right after PID) are legal: pkt_done fires with byte_count=0.
- Reset mid-packet: immediate return to IDLE with no pkt_done or rx_error pulse.

Decomposition:
- Package usb_rx_pkg holds:
  - state enum: IDLE, PID, DATA, EOP_WAIT
  - SYNC_BYTE default
  - PID code constants (OUT 4'b0001, IN 4'b1001, DATA0 4'b0011, DATA1 4'b1011, ACK 4'b0010, NAK 4'b1010)
- One sub-module, rx_bit_unstuff, owns ones_cnt. It outputs bit_accept, bit_drop and stuff_err from bit_valid, decoded and an enable from the controller.

Test Plan:
- Idle 1s, then SYNC, then PID 8'hD2 (ACK, sent LSB-first), then EOP with two SE0 samples -> pkt_start with rx_pid=4'h2; pkt_done with byte_count=0; no rx_error; receiving falls after the first J sample.
- SYNC, PID DATA0 (8'hC3), payload 8'hA5, 8'h3C, then EOP -> two rx_data_valid pulses carrying 8'hA5 then 8'h3C, then pkt_done with byte_count=2.
- Payload 8'hFF, 8'h01 with a stuffed 0 after six 1s -> stuffed bit dropped; bytes 8'hFF and 8'h01 delivered; no error.
- Seven consecutive 1s in payload -> rx_error pulse, state EOP_WAIT, no further rx_data_valid and no pkt_done.
- PID byte 8'h22 (check fails) -> rx_error, no pkt_start; EOP three bits into a data byte -> rx_error, no pkt_done.
- rst asserted after 3 payload bytes -> all outputs 0 immediately; the next clean packet is received correctly.
